pixel_cache_front: RTL and testbench
====================================

Name: pixel_cache_front

Overview:
- Direct-mapped write-back pixel cache front end, placed between the rasterizer pixel-write output and the main-memory state machine.
- Accepts pixel writes and services hits in place.
- On a miss it raises read_stall and reports whether the victim line is dirty. It then streams the victim line out, or fills the new line in, following the memory state machine's mem_state.
- It produces the cache_wr_en and cache_wr_done pulses that the memory state machine consumes.

Parameters:
- ADDR_W, 16, pixel word address width.
- DATA_W, 32, pixel word width.
- LINE_WORDS, 16, words per line; power of 2, at least 2.
- NUM_LINES, 8, lines; power of 2.
- Derived: OFF_W=log2(LINE_WORDS), IDX_W=log2(NUM_LINES), TAG_W=ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- px_valid  in  1  pixel write request.
- px_ready  out  1  request accepted this cycle.
- px_addr  in  ADDR_W  word address {tag,idx,off}.
- px_data  in  DATA_W  pixel value.
- read_stall  out  1  miss pending; to memory state machine.
- curr_bank_dirty  out  1  dirty bit of the line at the miss index.
- cache_wr_en  out  1  fill word written this cycle.
- cache_wr_done  out  1  last fill word written this cycle.
- mem_state  in  3  memory state machine state: IDLE=0, SEND_RD=1, WAIT_RD=2, LOAD=3, WRITE=4, DONE=7.
- mem_rd_valid  in  1  fill word present on mem_rd_data.
- mem_rd_data  in  DATA_W  fill word, delivered in offset order 0..LINE_WORDS-1.
- mem_addr  out  ADDR_W-OFF_W  line address for the current read or write-back.
- mem_wr_valid  out  1  write-back word valid.
- mem_wr_data  out  DATA_W  write-back word.
- mem_wr_ready  in  1  write-back word taken.

Behaviour:
- Storage: data RAM NUM_LINES x LINE_WORDS x DATA_W, plus per-line tag, valid bit and dirty bit.
- Reset (rst=0, asynchronous): all valid and dirty bits 0; state LOOKUP; fill and write-back counters 0; read_stall, cache_wr_en, cache_wr_done, mem_wr_valid and px_ready all 0; mem_addr 0. Data RAM contents are not reset.
- Reset mid-miss abandons the operation entirely; the line is left invalid.
- Hit condition: valid[idx] and tag[idx]==tag.
- LOOKUP, combinational: px_ready = px_valid & hit.
  - On acceptance, write px_data at {idx,off} and set dirty[idx] at the next edge.
  - Hit throughput: one per cycle, zero-cycle accept latency.
- LOOKUP with px_valid and no hit: px_ready=0. Capture tag, idx and wb=dirty[idx]; go to MISS.
  - From the next cycle read_stall=1, registered.
  - curr_bank_dirty = dirty[captured idx], registered, valid while read_stall=1; 0 otherwise.
  - mem_addr = {victim tag, idx} while dirty, else {captured tag, idx}.
- While in MISS, px_addr and px_data are ignored and px_ready=0. The requester must hold its request.
- Write-back (mem_state==WRITE):
  - mem_wr_valid=1, mem_wr_data = word[idx][wcnt].
  - wcnt increments on mem_wr_valid & mem_wr_ready.
  - mem_wr_valid drops after the word at wcnt=LINE_WORDS-1 is taken, and stays 0 until mem_state leaves WRITE.
- mem_state==DONE with wb=1:
  - Clear dirty[idx] and wb; reset wcnt.
  - read_stall stays 1, so the memory state machine re-enters with curr_bank_dirty=0 and issues the read.
- Fill: while mem_state is WAIT_RD or LOAD and mem_rd_valid=1:
  - Write mem_rd_data at word[idx][fcnt] and assert cache_wr_en=1 combinationally that cycle.
  - fcnt increments.
  - On fcnt==LINE_WORDS-1, also assert cache_wr_done=1 and set tag[idx] to the captured tag, valid[idx]=1, dirty[idx]=0.
- mem_rd_valid in any other mem_state is ignored: no write, no pulse.
- mem_state==DONE with wb=0 and fill complete: clear read_stall at that edge, reset fcnt, return to LOOKUP. The held request hits on the following cycle.
- Counter widths: fcnt and wcnt are OFF_W+1 bits and never wrap mid-line.
- Simultaneous events: a DONE arriving while wb=1 and wcnt<LINE_WORDS is a protocol error. Hold state and keep the line dirty; verification flags it by assertion.

Test Plan:
- Reset, then write addr 0x0000 data 0xA5 -> miss; read_stall=1 next cycle, curr_bank_dirty=0. Sequence SEND_RD, WAIT_RD, LOAD, DONE with 16 rd words -> cache_wr_en high for 16 cycles, cache_wr_done on word 15. Request accepted 1 cycle after DONE; line dirty.
- Back-to-back hits to 0x0001..0x0004 -> px_ready high 4 consecutive cycles; data RAM updated; no read_stall.
- Write 0x0080 (same idx 0, new tag) after a dirty line -> curr_bank_dirty=1, mem_addr=0x000. WRITE with mem_wr_ready toggled every other cycle -> exactly 16 words, 0xA5 first. After DONE: curr_bank_dirty=0, mem_addr=0x008, fill proceeds, then accept.
- mem_rd_valid asserted in SEND_RD -> no cache_wr_en, fcnt unchanged.
- rst low mid-fill (after word 7) -> all outputs 0 immediately; a re-request to the same address misses again with curr_bank_dirty=0.
- NUM_LINES=2, LINE_WORDS=2: alternating conflicting addresses -> each access misses with the correct dirty flag; cache_wr_done coincides with the second cache_wr_en.

Source files
------------

// File: rtl/pixel_cache_front.sv
// Direct-mapped write-back pixel cache front end: services pixel-write hits in place and
// sequences victim write-back and line fill under the memory state machine's mem_state.
module pixel_cache_front #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int NUM_LINES  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   px_valid,
  output logic                                   px_ready,
  input  logic [ADDR_W-1:0]                      px_addr,
  input  logic [DATA_W-1:0]                      px_data,
  output logic                                   read_stall,
  output logic                                   curr_bank_dirty,
  output logic                                   cache_wr_en,
  output logic                                   cache_wr_done,
  input  logic [2:0]                             mem_state,
  input  logic                                   mem_rd_valid,
  input  logic [DATA_W-1:0]                      mem_rd_data,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]   mem_addr,
  output logic                                   mem_wr_valid,
  output logic [DATA_W-1:0]                      mem_wr_data,
  input  logic                                   mem_wr_ready
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int CNT_W = OFF_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);

  localparam logic [2:0] MS_WAIT_RD = 3'd2;
  localparam logic [2:0] MS_LOAD    = 3'd3;
  localparam logic [2:0] MS_WRITE   = 3'd4;
  localparam logic [2:0] MS_DONE    = 3'd7;

  localparam logic [0:0] ST_LOOKUP = 1'b0;
  localparam logic [0:0] ST_MISS   = 1'b1;

  logic [DATA_W-1:0]    data_ram [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]     tag_ram  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  logic [0:0]           state;
  logic [TAG_W-1:0]     cap_tag;
  logic [IDX_W-1:0]     cap_idx;
  logic                 wb;
  logic [CNT_W-1:0]     fcnt;
  logic [CNT_W-1:0]     wcnt;

  logic [TAG_W-1:0]     px_tag;
  logic [IDX_W-1:0]     px_idx;
  logic [OFF_W-1:0]     px_off;
  logic                 hit;
  logic                 accept;
  logic                 fill_we;
  logic                 fill_last;
  logic                 wb_take;
  logic                 done_wb;
  logic                 done_fill;

  assign {px_tag, px_idx, px_off} = px_addr;

  assign hit      = valid_q[px_idx] && (tag_ram[px_idx] == px_tag);
  assign accept   = (state == ST_LOOKUP) && px_valid && hit;
  assign px_ready = accept;

  // Every miss-side output is a function of registered state only.
  assign read_stall      = (state == ST_MISS);
  assign curr_bank_dirty = read_stall && dirty_q[cap_idx];
  assign mem_addr        = !read_stall ? '0
                         : wb          ? {tag_ram[cap_idx], cap_idx}
                                       : {cap_tag, cap_idx};

  assign mem_wr_valid = read_stall && wb && (mem_state == MS_WRITE) && (wcnt != CNT_FULL);
  assign mem_wr_data  = data_ram[{cap_idx, wcnt[OFF_W-1:0]}];
  assign wb_take      = mem_wr_valid && mem_wr_ready;

  // A fill never runs while the victim is still owed to memory.
  assign fill_we       = read_stall && !wb && mem_rd_valid && (fcnt != CNT_FULL)
                      && ((mem_state == MS_WAIT_RD) || (mem_state == MS_LOAD));
  assign fill_last     = fill_we && (fcnt == CNT_LAST);
  assign cache_wr_en   = fill_we;
  assign cache_wr_done = fill_last;

  assign done_wb   = read_stall && wb  && (mem_state == MS_DONE) && (wcnt == CNT_FULL);
  assign done_fill = read_stall && !wb && (mem_state == MS_DONE) && (fcnt == CNT_FULL);

  // NOTE: data and tag storage carry no reset so they can map onto plain RAM; valid_q
  // alone decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_ram[{px_idx, px_off}] <= px_data;
    end else if (fill_we) begin
      data_ram[{cap_idx, fcnt[OFF_W-1:0]}] <= mem_rd_data;
    end
    if (fill_last) begin
      tag_ram[cap_idx] <= cap_tag;
    end
  end

  // NOTE: non-blocking assignments here, so every condition below reads pre-edge state
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_LOOKUP;
      valid_q <= '0;
      dirty_q <= '0;
      cap_tag <= '0;
      cap_idx <= '0;
      wb      <= 1'b0;
      fcnt    <= '0;
      wcnt    <= '0;
    end else if (state == ST_LOOKUP) begin
      if (accept) begin
        dirty_q[px_idx] <= 1'b1;
      end else if (px_valid) begin
        cap_tag <= px_tag;
        cap_idx <= px_idx;
        wb      <= dirty_q[px_idx];
        state   <= ST_MISS;
      end
    end else begin
      if (wb_take) begin
        wcnt <= wcnt + 1'b1;
      end
      if (fill_we) begin
        fcnt <= fcnt + 1'b1;
      end
      if (fill_last) begin
        valid_q[cap_idx] <= 1'b1;
        dirty_q[cap_idx] <= 1'b0;
      end
      if (done_wb) begin
        dirty_q[cap_idx] <= 1'b0;
        wb               <= 1'b0;
        wcnt             <= '0;
      end
      if (done_fill) begin
        fcnt  <= '0;
        state <= ST_LOOKUP;
      end
    end
  end

  // DONE before the last write-back word is taken is a memory-side protocol error;
  // the line stays dirty and the miss holds.
  a_done_before_wb_complete: assert property (@(posedge clk) disable iff (!rst)
    !(read_stall && wb && (mem_state == MS_DONE) && (wcnt != CNT_FULL)));

endmodule

// File: tb/tb_pixel_cache_front.sv
// Bench for pixel_cache_front: acts as rasterizer and memory state machine, and checks the
// cache against a line-level model backed by a sparse main-memory image.
module tb_pixel_cache_front;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic        px_valid;
  logic [15:0] px_addr;
  logic [31:0] px_data;
  logic [2:0]  mem_state;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_ready;

  logic        a_px_ready, a_stall, a_cbd, a_wr_en, a_wr_done, a_wr_valid;
  logic [11:0] a_mem_addr;
  logic [31:0] a_wr_data;
  logic        b_px_ready, b_stall, b_cbd, b_wr_en, b_wr_done, b_wr_valid;
  logic [14:0] b_mem_addr;
  logic [31:0] b_wr_data;

  logic        o_px_ready, o_stall, o_cbd, o_wr_en, o_wr_done, o_wr_valid;
  logic [15:0] o_mem_addr;
  logic [31:0] o_wr_data;

  pixel_cache_front dut_a (
    .clk(clk), .rst(rst_a),
    .px_valid(px_valid), .px_ready(a_px_ready), .px_addr(px_addr), .px_data(px_data),
    .read_stall(a_stall), .curr_bank_dirty(a_cbd),
    .cache_wr_en(a_wr_en), .cache_wr_done(a_wr_done),
    .mem_state(mem_state), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_addr(a_mem_addr), .mem_wr_valid(a_wr_valid), .mem_wr_data(a_wr_data),
    .mem_wr_ready(mem_wr_ready)
  );

  pixel_cache_front #(.ADDR_W(16), .DATA_W(32), .LINE_WORDS(2), .NUM_LINES(2)) dut_b (
    .clk(clk), .rst(rst_b),
    .px_valid(px_valid), .px_ready(b_px_ready), .px_addr(px_addr), .px_data(px_data),
    .read_stall(b_stall), .curr_bank_dirty(b_cbd),
    .cache_wr_en(b_wr_en), .cache_wr_done(b_wr_done),
    .mem_state(mem_state), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_addr(b_mem_addr), .mem_wr_valid(b_wr_valid), .mem_wr_data(b_wr_data),
    .mem_wr_ready(mem_wr_ready)
  );

  always_comb begin
    if (sel) begin
      o_px_ready = b_px_ready; o_stall = b_stall; o_cbd = b_cbd; o_wr_en = b_wr_en;
      o_wr_done = b_wr_done; o_wr_valid = b_wr_valid; o_wr_data = b_wr_data;
      o_mem_addr = 16'(b_mem_addr);
    end else begin
      o_px_ready = a_px_ready; o_stall = a_stall; o_cbd = a_cbd; o_wr_en = a_wr_en;
      o_wr_done = a_wr_done; o_wr_valid = a_wr_valid; o_wr_data = a_wr_data;
      o_mem_addr = 16'(a_mem_addr);
    end
  end

  // Reference model: cache lines by index, plus main memory as a sparse word image.
  int          lw, nl;
  bit          m_valid [8];
  bit          m_dirty [8];
  int          m_tag   [8];
  logic [31:0] m_data  [8][16];
  logic [31:0] mem_img [int];

  int n_checks, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fill_word(input int a);
    if (!mem_img.exists(a)) mem_img[a] = $urandom;
    return mem_img[a];
  endfunction

  task automatic check_quiet();
    check("rst_px_ready", 32'(o_px_ready), 0);
    check("rst_stall",    32'(o_stall), 0);
    check("rst_cbd",      32'(o_cbd), 0);
    check("rst_wr_en",    32'(o_wr_en), 0);
    check("rst_wr_done",  32'(o_wr_done), 0);
    check("rst_wr_valid", 32'(o_wr_valid), 0);
    check("rst_mem_addr", 32'(o_mem_addr), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    mem_state = S_IDLE; mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
    px_valid = 1'b1; px_addr = 16'h0000;
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    #2;
    check_quiet();
    model_reset();
    px_valid = 1'b0;
    adv();
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    adv();
  endtask

  task automatic write_back(input int idx, input int vla, input int new_la);
    int n = 0;
    int guard = 0;
    adv();
    mem_state = S_WRITE;
    while (n < lw && guard < 400) begin
      mem_wr_ready = 1'($urandom_range(0, 1));
      settle();
      check("wb_valid", 32'(o_wr_valid), 1);
      if (mem_wr_ready) begin
        check("wb_data", o_wr_data, m_data[idx][n]);
        mem_img[vla * lw + n] = m_data[idx][n];
        n++;
      end
      adv();
      guard++;
    end
    check("wb_count", n, lw);
    mem_wr_ready = 1'b1;
    settle();
    check("wb_valid_drop", 32'(o_wr_valid), 0);
    adv();
    mem_wr_ready = 1'b0;
    mem_state = S_DONE;
    settle();
    adv();
    mem_state = S_IDLE;
    m_dirty[idx] = 1'b0;
    settle();
    check("wb_cbd_clear",  32'(o_cbd), 0);
    check("wb_stall_held", 32'(o_stall), 1);
    check("fill_mem_addr", 32'(o_mem_addr), new_la);
  endtask

  task automatic fill(input int idx, input int tg, input int la);
    int n = 0;
    int guard = 0;
    logic [31:0] w;
    adv();
    mem_state = S_SEND; mem_rd_valid = 1'b1; mem_rd_data = $urandom;
    settle();
    check("send_rd_ignored", 32'(o_wr_en), 0);
    adv();
    mem_state = S_WAIT; mem_rd_valid = 1'b0;
    settle();
    adv();
    while (n < lw && guard < 400) begin
      mem_state    = (n == 0 && $urandom_range(0, 1) == 1) ? S_WAIT : S_LOAD;
      mem_rd_valid = ($urandom_range(0, 3) != 0);
      w            = fill_word(la * lw + n);
      mem_rd_data  = w;
      settle();
      check("fill_wr_en",   32'(o_wr_en),   32'(mem_rd_valid));
      check("fill_wr_done", 32'(o_wr_done), 32'(mem_rd_valid && n == lw - 1));
      if (mem_rd_valid) begin
        m_data[idx][n] = w;
        n++;
      end
      adv();
      guard++;
    end
    check("fill_count", n, lw);
    mem_rd_valid = 1'b0;
    mem_state = S_DONE;
    settle();
    check("done_stall", 32'(o_stall), 1);
    adv();
    mem_state = S_IDLE;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    m_dirty[idx] = 1'b0;
  endtask

  // One pixel write, end to end: a miss runs write-back and fill, then the held request hits.
  task automatic do_write(input int addr, input logic [31:0] data);
    int off, la, idx, tg;
    bit wb;
    off = addr % lw;
    la  = addr / lw;
    idx = la % nl;
    tg  = la / nl;
    px_valid = 1'b1; px_addr = 16'(addr); px_data = data;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      wb = m_dirty[idx];
      settle();
      check("miss_ready", 32'(o_px_ready), 0);
      adv();
      settle();
      check("miss_stall",    32'(o_stall), 1);
      check("miss_cbd",      32'(o_cbd), 32'(wb));
      check("stall_ready",   32'(o_px_ready), 0);
      check("miss_mem_addr", 32'(o_mem_addr), wb ? m_tag[idx] * nl + idx : la);
      if (wb) write_back(idx, m_tag[idx] * nl + idx, la);
      fill(idx, tg, la);
    end
    settle();
    check("hit_ready", 32'(o_px_ready), 1);
    check("hit_stall", 32'(o_stall), 0);
    adv();
    m_data[idx][off] = data;
    m_dirty[idx] = 1'b1;
    px_valid = 1'b0;
  endtask

  task automatic reset_mid_fill();
    px_valid = 1'b1; px_addr = 16'h0030; px_data = 32'h0000_1234;
    settle();
    adv();
    mem_state = S_LOAD;
    for (int i = 0; i < 8; i++) begin
      mem_rd_valid = 1'b1; mem_rd_data = $urandom;
      settle();
      adv();
    end
    #2 rst_a = 1'b0;
    #1;
    check_quiet();
    model_reset();
    mem_state = S_IDLE; mem_rd_valid = 1'b0; px_valid = 1'b0;
    adv();
    rst_a = 1'b1;
    adv();
    do_write(16'h0030, 32'h0000_1234);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0;
    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
    px_valid = 1'b0; px_addr = '0; px_data = '0;
    mem_state = S_IDLE; mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ready = 1'b0;
    lw = 16; nl = 8;
    #12;
    do_reset();

    do_write(16'h0000, 32'h0000_00A5);
    for (int a = 1; a <= 4; a++) do_write(a, 32'h100 + a);
    do_write(16'h0080, 32'h0000_5A5A);
    reset_mid_fill();
    for (int i = 0; i < 60; i++)
      do_write($urandom_range(0, 3) * 128 + $urandom_range(0, 127), $urandom);

    sel = 1'b1; lw = 2; nl = 2;
    rst_a = 1'b0;
    mem_img.delete();
    do_reset();
    for (int i = 0; i < 8; i++) do_write((i % 2 == 1) ? 4 : 0, $urandom);
    for (int i = 0; i < 30; i++) do_write($urandom_range(0, 15), $urandom);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
